load_ext_pipe: RTL and testbench
================================

Name: load_ext_pipe

Overview:
- Parametrised, registered successor to the memory-stage load-data extender.
- Takes a raw memory word, the load op, the byte address, the old rt value and a destination tag. Produces the aligned and extended writeback value one cycle later.
- Uses valid/ready handshakes on both sides. Sits between data-memory read data and the M/W pipeline register.
- Adds 64-bit lanes, LWL/LWR merging, LD, misalignment detection and backpressure.

Parameters:
- DATA_W, 32, memory/register data width; legal values 32 or 64.
- TAG_W, 5, width of the destination-register tag carried alongside the data.
- OFS_W, derived = log2(DATA_W/8), byte-offset width (2 or 3); localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept this cycle
- in_op  input  3  load op: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LD
- in_addr  input  OFS_W  low bits of effective address
- in_din  input  DATA_W  raw aligned memory word, little-endian lanes
- in_rt  input  DATA_W  current rt value (LWL/LWR merge source)
- in_tag  input  TAG_W  destination register
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- out_data  output  DATA_W  extended result
- out_tag  output  TAG_W  registered copy of in_tag
- out_err  output  1  address error for this result
- err_cnt  output  16  misalignment count (see Optional Feature)

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_tag=0, out_err=0, err_cnt=0. A transfer in flight at reset assertion is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on in_valid && in_ready. The result is registered at that edge, so latency is 1 cycle.
  - out_valid rises the cycle after accept.
  - Simultaneous pop and push: the register is overwritten with the new result and out_valid stays 1, giving full throughput.
- Stall: while out_valid && !out_ready, all out_* hold stable and in_ready=0.
- Word select (DATA_W=64): for word ops (LW, LWL, LWR), W = in_din[63:32] if in_addr[2]=1, else in_din[31:0]. For DATA_W=32, W = in_din.
- Op results:
  - LB/LBU: byte lane in_addr. LB sign-extends to DATA_W; LBU zero-extends.
  - LH/LHU: halfword lane in_addr[OFS_W-1:1]. LH sign-extends; LHU zero-extends.
  - LW: W sign-extended to DATA_W (identity when DATA_W=32).
  - LWL, with b = in_addr[1:0]: merged word M = {W[8b+7:0], rt[31-8(b+1):0]}. For b=3, M = W.
  - LWR, with b = in_addr[1:0]: M = {rt[31:32-8b], W[31:8b]}. For b=0, M = W.
  - LWL/LWR result: M sign-extended to DATA_W.
  - LD: in_din. Legal only when DATA_W=64.
- Errors (out_err=1, out_data=0):
  - LH/LHU with in_addr[0]=1.
  - LW with in_addr[1:0]≠0.
  - LD with in_addr[2:0]≠0.
  - LD when DATA_W=32.
  - LWL, LWR, LB and LBU never error.
- out_tag is always passed through, including on error.

Optional Feature:
- Macro LDEXT_ERRCNT_EN.
- When defined: err_cnt increments by 1 on every accepted transfer whose computed out_err=1. It saturates at 16'hFFFF and is cleared only by reset.
- When undefined: err_cnt is constant 0 and no counter flops are synthesised.

Test Plan:
- DATA_W=32. LB, addr=3, din=32'h80FF_1234 → next cycle out_valid=1, out_data=32'hFFFF_FF80. Repeat with LBU → 32'h0000_0080.
- DATA_W=32. LWL, addr=1, din=32'hAABB_CCDD, rt=32'h1122_3344 → out_data=32'hCCDD_3344. LWR, addr=1, same inputs → 32'h11AA_BBCC.
- DATA_W=64. LW, addr=4, din=64'h8000_0001_0000_0002 → out_data=64'hFFFF_FFFF_8000_0001. LD, addr=0 → out_data equals din.
- LH, addr=1, tag=5'd9 → out_err=1, out_data=0, out_tag=9. With LDEXT_ERRCNT_EN defined, err_cnt=1; undefined, err_cnt=0.
- Backpressure: out_ready=0 for 3 cycles after a result → in_ready=0 and out_* held. Then out_ready=1 with in_valid=1 → back-to-back results every cycle with no loss or duplication.
- Assert reset mid-stall with out_valid=1 → out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/load_ext_pipe.sv
// Registered load-data aligner/extender with valid/ready on both sides.
// Optional misalignment counter is enabled with the LDEXT_ERRCNT_EN macro.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [$clog2(DATA_W/8)-1:0]   in_addr,
  input  logic [DATA_W-1:0]             in_din,
  input  logic [DATA_W-1:0]             in_rt,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_err,
  output logic [15:0]                   err_cnt
);
  localparam int OFS_W = $clog2(DATA_W/8);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4,
    OP_LWL = 3'd5,
    OP_LWR = 3'd6,
    OP_LD  = 3'd7
  } op_e;

  // Handshake: a transfer happens on a side when valid && ready are both high
  // at a rising edge; the output register may be refilled in the same cycle it
  // is drained, and it holds all out_* stable while out_valid && !out_ready.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_err_q, out_err_d;
  logic              accept;

  logic [31:0]       word_v;
  logic [DATA_W-1:0] byte_sh, half_sh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [1:0]        b_ofs;
  logic [4:0]        sh_lo, sh_hi;
  logic [31:0]       lwl_m, lwr_m;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              unused_rt_hi;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Word lane: the upper half of a 64-bit beat is chosen by address bit 2.
  assign word_v  = (DATA_W == 64 && in_addr[OFS_W-1]) ? in_din[DATA_W-1 -: 32] : in_din[31:0];
  assign byte_sh = in_din >> {in_addr, 3'b000};
  assign half_sh = in_din >> {in_addr[OFS_W-1:1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];
  assign b_ofs   = in_addr[1:0];
  assign sh_hi   = {~b_ofs, 3'b000};
  assign sh_lo   = {b_ofs, 3'b000};

  // LWL keeps the low 8*(3-b) bits of rt; LWR keeps the high 8*b bits of rt.
  assign lwl_m = (word_v << sh_hi) | (in_rt[31:0] & ~(32'hFFFF_FFFF << sh_hi));
  assign lwr_m = (word_v >> sh_lo) | (in_rt[31:0] & ~(32'hFFFF_FFFF >> sh_lo));

  assign unused_rt_hi = ^in_rt;

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_e'(in_op))
      OP_LB:  res_data = DATA_W'(signed'(byte_v));
      OP_LBU: res_data = DATA_W'(byte_v);
      OP_LH: begin
        res_err  = in_addr[0];
        res_data = DATA_W'(signed'(half_v));
      end
      OP_LHU: begin
        res_err  = in_addr[0];
        res_data = DATA_W'(half_v);
      end
      OP_LW: begin
        res_err  = (in_addr[1:0] != 2'b00);
        res_data = DATA_W'(signed'(word_v));
      end
      OP_LWL: res_data = DATA_W'(signed'(lwl_m));
      OP_LWR: res_data = DATA_W'(signed'(lwr_m));
      OP_LD: begin
        res_err  = (DATA_W != 64) || (in_addr != '0);
        res_data = in_din;
      end
      default: res_data = '0;
    endcase
    if (res_err) res_data = '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_tag_d   = in_tag;
      out_err_d   = res_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

`ifdef LDEXT_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted faulting loads.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && res_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= 16'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: one 32-bit and one 64-bit instance.
module tb_load_ext_pipe;
  logic clk;
  logic reset;

  // 32-bit instance signals
  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_err32;
  logic [2:0]  in_op32;
  logic [1:0]  in_addr32;
  logic [31:0] in_din32, in_rt32, out_data32;
  logic [4:0]  in_tag32, out_tag32;
  logic [15:0] err_cnt32;

  // 64-bit instance signals
  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_err64;
  logic [2:0]  in_op64;
  logic [2:0]  in_addr64;
  logic [63:0] in_din64, in_rt64, out_data64;
  logic [4:0]  in_tag64, out_tag64;
  logic [15:0] err_cnt64;

  // Expected entries packed as {err, tag[4:0], data[63:0]}
  logic [69:0] exp_q32[$];
  logic [69:0] exp_q64[$];

  int checks = 0;
  int failures = 0;
  int pushes32 = 0, pops32 = 0, pushes64 = 0, pops64 = 0;
  int exp_cnt32 = 0, exp_cnt64 = 0;

  load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op32),
    .in_addr(in_addr32), .in_din(in_din32), .in_rt(in_rt32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_tag(out_tag32), .out_err(out_err32), .err_cnt(err_cnt32)
  );

  load_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op64),
    .in_addr(in_addr64), .in_din(in_din64), .in_rt(in_rt64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_tag(out_tag64), .out_err(out_err64), .err_cnt(err_cnt64)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic send32(input logic [2:0] op, input logic [1:0] addr, input logic [31:0] din,
                        input logic [31:0] rt, input logic [4:0] tag,
                        input logic [31:0] exp_d, input logic exp_e);
    bit ok = 0;
    in_valid32 = 1'b1; in_op32 = op; in_addr32 = addr;
    in_din32 = din; in_rt32 = rt; in_tag32 = tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready32) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send32_timeout actual=in_ready_low expected=in_ready_high");
      in_valid32 = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q32.push_back({exp_e, tag, 32'h0, exp_d});
    pushes32++;
`ifdef LDEXT_ERRCNT_EN
    if (exp_e) exp_cnt32++;
`endif
    #1 in_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [2:0] op, input logic [2:0] addr, input logic [63:0] din,
                        input logic [63:0] rt, input logic [4:0] tag,
                        input logic [63:0] exp_d, input logic exp_e);
    bit ok = 0;
    in_valid64 = 1'b1; in_op64 = op; in_addr64 = addr;
    in_din64 = din; in_rt64 = rt; in_tag64 = tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready64) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send64_timeout actual=in_ready_low expected=in_ready_high");
      in_valid64 = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q64.push_back({exp_e, tag, exp_d});
    pushes64++;
`ifdef LDEXT_ERRCNT_EN
    if (exp_e) exp_cnt64++;
`endif
    #1 in_valid64 = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_q32.size() == 0 && exp_q64.size() == 0) break;
    end
    check("drain_q32_empty", 64'(exp_q32.size()), 64'd0);
    check("drain_q64_empty", 64'(exp_q64.size()), 64'd0);
    #1;
  endtask

  // Scoreboard monitors: compare whenever a result is consumed.
  always @(negedge clk) begin
    if (!reset && out_valid32 && out_ready32) begin
      logic [69:0] e;
      checks++;
      if (exp_q32.size() == 0) begin
        failures++;
        $display("FAIL mon32_unexpected actual=data:%h tag:%0d expected=no_result", out_data32, out_tag32);
      end else begin
        e = exp_q32.pop_front();
        pops32++;
        if ({out_err32, out_tag32, out_data32} !== {e[69], e[68:64], e[31:0]}) begin
          failures++;
          $display("FAIL mon32 actual=err:%b tag:%0d data:%h expected=err:%b tag:%0d data:%h",
                   out_err32, out_tag32, out_data32, e[69], e[68:64], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid64 && out_ready64) begin
      logic [69:0] e;
      checks++;
      if (exp_q64.size() == 0) begin
        failures++;
        $display("FAIL mon64_unexpected actual=data:%h tag:%0d expected=no_result", out_data64, out_tag64);
      end else begin
        e = exp_q64.pop_front();
        pops64++;
        if ({out_err64, out_tag64, out_data64} !== e) begin
          failures++;
          $display("FAIL mon64 actual=err:%b tag:%0d data:%h expected=err:%b tag:%0d data:%h",
                   out_err64, out_tag64, out_data64, e[69], e[68:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid32 = 0; in_op32 = 0; in_addr32 = 0; in_din32 = 0; in_rt32 = 0; in_tag32 = 0;
    in_valid64 = 0; in_op64 = 0; in_addr64 = 0; in_din64 = 0; in_rt64 = 0; in_tag64 = 0;
    out_ready32 = 1'b1; out_ready64 = 1'b1;
    #2;
    check("rst_valid32", 64'(out_valid32), 64'd0);
    check("rst_data32",  64'(out_data32),  64'd0);
    check("rst_tag32",   64'(out_tag32),   64'd0);
    check("rst_err32",   64'(out_err32),   64'd0);
    check("rst_cnt32",   64'(err_cnt32),   64'd0);
    check("rst_valid64", 64'(out_valid64), 64'd0);
    check("rst_cnt64",   64'(err_cnt64),   64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // 32-bit vectors
    send32(3'd1, 2'd3, 32'h80FF_1234, 32'h0, 5'd1, 32'hFFFF_FF80, 1'b0);
    @(negedge clk);
    check("lb_latency_valid", 64'(out_valid32), 64'd1);
    @(posedge clk); #1;
    send32(3'd2, 2'd3, 32'h80FF_1234, 32'h0, 5'd2, 32'h0000_0080, 1'b0);
    send32(3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd3, 32'hCCDD_3344, 1'b0);
    send32(3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd4, 32'h11AA_BBCC, 1'b0);
    send32(3'd3, 2'd1, 32'h80FF_1234, 32'h0, 5'd9, 32'h0, 1'b1);
    check("errcnt_after_lh", 64'(err_cnt32), 64'(exp_cnt32));
    send32(3'd4, 2'd2, 32'h80FF_1234, 32'h0, 5'd5, 32'h0000_80FF, 1'b0);
    send32(3'd3, 2'd2, 32'h80FF_1234, 32'h0, 5'd6, 32'hFFFF_80FF, 1'b0);
    send32(3'd3, 2'd0, 32'h80FF_1234, 32'h0, 5'd7, 32'h0000_1234, 1'b0);
    send32(3'd0, 2'd0, 32'h80FF_1234, 32'h0, 5'd8, 32'h80FF_1234, 1'b0);
    send32(3'd0, 2'd2, 32'h80FF_1234, 32'h0, 5'd10, 32'h0, 1'b1);
    send32(3'd7, 2'd0, 32'h80FF_1234, 32'h0, 5'd11, 32'h0, 1'b1);
    send32(3'd5, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd12, 32'hAABB_CCDD, 1'b0);
    send32(3'd5, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd13, 32'hDD22_3344, 1'b0);
    send32(3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd14, 32'h1122_33AA, 1'b0);
    send32(3'd6, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd15, 32'hAABB_CCDD, 1'b0);
    drain();

    // Backpressure: hold one result for three cycles, then stream.
    out_ready32 = 1'b0;
    send32(3'd1, 2'd0, 32'h0000_007F, 32'h0, 5'd16, 32'h0000_007F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready32), 64'd0);
      check("stall_valid", 64'(out_valid32), 64'd1);
      check("stall_data_tag", {27'd0, out_tag32, out_data32}, {27'd0, 5'd16, 32'h0000_007F});
    end
    @(posedge clk); #1 out_ready32 = 1'b1;
    send32(3'd2, 2'd1, 32'h0000_AB00, 32'h0, 5'd17, 32'h0000_00AB, 1'b0);
    send32(3'd1, 2'd1, 32'h0000_AB00, 32'h0, 5'd18, 32'hFFFF_FFAB, 1'b0);
    send32(3'd4, 2'd0, 32'h0000_FFFE, 32'h0, 5'd19, 32'h0000_FFFE, 1'b0);
    send32(3'd3, 2'd0, 32'h0000_FFFE, 32'h0, 5'd20, 32'hFFFF_FFFE, 1'b0);
    drain();
    check("count_pops32", 64'(pops32), 64'(pushes32));
    check("errcnt32_total", 64'(err_cnt32), 64'(exp_cnt32));

    // 64-bit vectors
    send64(3'd0, 3'd4, 64'h8000_0001_0000_0002, 64'h0, 5'd1, 64'hFFFF_FFFF_8000_0001, 1'b0);
    send64(3'd0, 3'd0, 64'h8000_0001_0000_0002, 64'h0, 5'd2, 64'h0000_0000_0000_0002, 1'b0);
    send64(3'd7, 3'd0, 64'h8000_0001_0000_0002, 64'h0, 5'd3, 64'h8000_0001_0000_0002, 1'b0);
    send64(3'd7, 3'd4, 64'h8000_0001_0000_0002, 64'h0, 5'd4, 64'h0, 1'b1);
    send64(3'd7, 3'd2, 64'h8000_0001_0000_0002, 64'h0, 5'd5, 64'h0, 1'b1);
    send64(3'd1, 3'd7, 64'h8000_0001_0000_0002, 64'h0, 5'd6, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send64(3'd4, 3'd6, 64'h8000_0001_0000_0002, 64'h0, 5'd7, 64'h0000_0000_0000_8000, 1'b0);
    send64(3'd5, 3'd5, 64'hAABB_CCDD_0000_0000, 64'h0000_0000_1122_3344, 5'd8,
           64'hFFFF_FFFF_CCDD_3344, 1'b0);
    send64(3'd6, 3'd5, 64'hAABB_CCDD_0000_0000, 64'h0000_0000_1122_3344, 5'd9,
           64'h0000_0000_11AA_BBCC, 1'b0);
    drain();
    check("count_pops64", 64'(pops64), 64'(pushes64));
    check("errcnt64_total", 64'(err_cnt64), 64'(exp_cnt64));

    // Asynchronous reset during a stall
    out_ready32 = 1'b0;
    send32(3'd3, 2'd3, 32'h1234_5678, 32'h0, 5'd21, 32'h0, 1'b1);
    @(negedge clk);
    check("prereset_valid", 64'(out_valid32), 64'd1);
    check("prereset_cnt", 64'(err_cnt32), 64'(exp_cnt32));
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid32), 64'd0);
    check("async_rst_cnt", 64'(err_cnt32), 64'd0);
    check("async_rst_data", 64'(out_data32), 64'd0);
    void'(exp_q32.pop_back());
    pushes32--;
    exp_cnt32 = 0;
    @(posedge clk); #1 reset = 1'b0; out_ready32 = 1'b1;
    send32(3'd2, 2'd0, 32'h0000_00FF, 32'h0, 5'd22, 32'h0000_00FF, 1'b0);
    drain();
    check("final_pops32", 64'(pops32), 64'(pushes32));
    check("final_cnt32", 64'(err_cnt32), 64'(exp_cnt32));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
